// File: rtl/upg_pkg.sv
// Shared definitions for the program-ROM upgrade loader: state codes, sync byte, ROM address width.
package upg_pkg;

  localparam int unsigned UPG_ADR_W = 14;
  localparam logic [7:0]  UPG_MAGIC = 8'hA5;

  typedef logic [2:0] upg_state_t;

  localparam upg_state_t ST_IDLE   = 3'd0;
  localparam upg_state_t ST_SYNC   = 3'd1;
  localparam upg_state_t ST_CNT_LO = 3'd2;
  localparam upg_state_t ST_CNT_HI = 3'd3;
  localparam upg_state_t ST_DATA   = 3'd4;
  localparam upg_state_t ST_DONE   = 3'd5;
  localparam upg_state_t ST_ERR    = 3'd6;

  // States in which an inter-byte silence aborts the session.
  function automatic logic upg_timed(input upg_state_t s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/upg_word_pack.sv
// Little-endian byte-to-word assembler; o_word_rdy pulses the cycle after the 4th byte.
// o_word only changes on completion, so it holds the last finished word; no backpressure.
module upg_word_pack (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte_dat,
  output logic [1:0]  o_byte_idx,
  output logic        o_word_rdy,
  output logic [31:0] o_word
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;
  logic [31:0] r_word;
  logic        r_rdy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx   <= '0;
      r_shift <= '0;
      r_word  <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (i_clr) begin
        r_idx   <= '0;
        r_shift <= '0;
      end else if (i_byte_vld) begin
        if (r_idx == 2'd3) begin
          r_word <= {i_byte_dat, r_shift};
          r_rdy  <= 1'b1;
          r_idx  <= '0;
        end else begin
          r_shift[{r_idx, 3'b000} +: 8] <= i_byte_dat;
          r_idx                         <= r_idx + 2'd1;
        end
      end
    end
  end

  assign o_byte_idx = r_idx;
  assign o_word_rdy = r_rdy;
  assign o_word     = r_word;

endmodule

// File: rtl/upg_loader.sv
// UART-fed program-ROM loader: MAGIC, 16-bit LE word count, then LE 32-bit words.
// One write pulse per word a cycle after its 4th byte; accepts a byte every cycle, no backpressure.
module upg_loader
  import upg_pkg::*;
#(
  parameter logic [7:0]  MAGIC     = UPG_MAGIC,
  parameter logic [31:0] TIMEOUT   = 32'd50_000_000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  output logic                 upg_wen_o,
  output logic [UPG_ADR_W-1:0] upg_adr_o,
  output logic [31:0]          upg_dat_o,
  output logic                 upg_done_o,
  output logic                 upg_rst_o,
  output logic                 err_o
);

  localparam logic [16:0]        LP_MAX_WORDS = 17'(MAX_WORDS);
  localparam logic [UPG_ADR_W:0] LP_IDX_ONE   = {{UPG_ADR_W{1'b0}}, 1'b1};

  upg_state_t           r_state;
  logic [15:0]          r_n;
  logic [UPG_ADR_W:0]   r_word_idx;
  logic [UPG_ADR_W-1:0] r_adr;
  logic [31:0]          r_tmo;

  logic        w_timed;
  logic        w_tmo_exp;
  logic        w_start;
  logic        w_byte_vld;
  logic        w_last_byte;
  logic        w_last_word;
  logic        w_word_rdy;
  logic [1:0]  w_byte_idx;
  logic [31:0] w_word;
  logic [15:0] w_n_new;

  assign w_timed     = upg_timed(r_state);
  // A byte landing on the expiry cycle wins over the timeout.
  assign w_tmo_exp   = w_timed && !rx_valid_i && (r_tmo == TIMEOUT - 32'd1);
  assign w_start     = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_byte_vld  = rx_valid_i && (r_state == ST_DATA);
  assign w_last_byte = w_byte_vld && (w_byte_idx == 2'd3);
  assign w_n_new     = {rx_data_i, r_n[7:0]};
  assign w_last_word = w_word_rdy && ({1'b0, r_word_idx} == r_n);

  upg_word_pack u_pack (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start),
    .i_byte_vld (w_byte_vld),
    .i_byte_dat (rx_data_i),
    .o_byte_idx (w_byte_idx),
    .o_word_rdy (w_word_rdy),
    .o_word     (w_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_n        <= '0;
      r_word_idx <= '0;
      r_adr      <= '0;
      r_tmo      <= '0;
    end else begin
      r_tmo <= (w_timed && !rx_valid_i) ? r_tmo + 32'd1 : '0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (w_start) begin
            r_state    <= ST_SYNC;
            r_word_idx <= '0;
            r_n        <= '0;
          end
        end
        ST_SYNC: begin
          if (rx_valid_i && (rx_data_i == MAGIC)) r_state <= ST_CNT_LO;
        end
        ST_CNT_LO: begin
          if (rx_valid_i) begin
            r_n[7:0] <= rx_data_i;
            r_state  <= ST_CNT_HI;
          end else if (w_tmo_exp) begin
            r_state <= ST_ERR;
          end
        end
        ST_CNT_HI: begin
          if (rx_valid_i) begin
            r_n <= w_n_new;
            if (w_n_new == 16'd0)                       r_state <= ST_DONE;
            else if ({1'b0, w_n_new} > LP_MAX_WORDS)    r_state <= ST_ERR;
            else                                        r_state <= ST_DATA;
          end else if (w_tmo_exp) begin
            r_state <= ST_ERR;
          end
        end
        ST_DATA: begin
          if (w_last_word)    r_state <= ST_DONE;
          else if (w_tmo_exp) r_state <= ST_ERR;
          // Address is latched with the completing byte so it lines up with the write pulse.
          if (w_last_byte) begin
            r_adr      <= r_word_idx[UPG_ADR_W-1:0];
            r_word_idx <= r_word_idx + LP_IDX_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign upg_wen_o  = w_word_rdy && (r_state == ST_DATA);
  assign upg_adr_o  = r_adr;
  assign upg_dat_o  = w_word;
  assign upg_done_o = (r_state == ST_DONE);
  assign err_o      = (r_state == ST_ERR);
  assign upg_rst_o  = (r_state == ST_SYNC) || w_timed;

endmodule

// File: tb/tb_upg_loader.sv
// Randomized scoreboard bench for upg_loader against a byte-stream reference model.
module tb_upg_loader;

  localparam int TMO  = 16;
  localparam int MAXW = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        upg_wen_o;
  logic [13:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        upg_rst_o;
  logic        err_o;

  always #5 clk = ~clk;

  upg_loader #(.MAGIC(8'hA5), .TIMEOUT(32'd16), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .rx_valid_i (rx_valid_i),
    .rx_data_i  (rx_data_i),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .upg_rst_o  (upg_rst_o),
    .err_o      (err_o)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [45:0] exp_q[$];
  logic [7:0]  bq[$];
  int          gq[$];
  int          exp_res;      // 0 still syncing, 1 done, 2 error
  logic [13:0] exp_adr = '0;
  logic [31:0] exp_dat = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [45:0] e;
    forever begin
      @(negedge clk);
      if (upg_wen_o) begin
        chk("wen_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("write_adr_dat", {18'd0, upg_adr_o, upg_dat_o}, {18'd0, e});
        end
      end
    end
  endtask

  // Reference: walk the byte stream with its idle gaps and derive writes and final status.
  task automatic model();
    int phase = 0;
    int n = 0;
    int widx = 0;
    int bidx = 0;
    logic [31:0] word = '0;
    exp_res = 0;
    for (int i = 0; i < bq.size(); i++) begin
      if (exp_res != 0) break;
      if (phase != 0 && gq[i] >= TMO) begin
        exp_res = 2;
        break;
      end
      case (phase)
        0: if (bq[i] == 8'hA5) phase = 1;
        1: begin n = int'(bq[i]); phase = 2; end
        2: begin
          n = n + 256 * int'(bq[i]);
          if (n == 0)         exp_res = 1;
          else if (n > MAXW)  exp_res = 2;
          else                phase = 3;
        end
        default: begin
          word = word | (32'(bq[i]) << (8 * bidx));
          bidx++;
          if (bidx == 4) begin
            exp_q.push_back({14'(widx), word});
            exp_adr = 14'(widx);
            exp_dat = word;
            widx++;
            word = '0;
            bidx = 0;
            if (widx == n) exp_res = 1;
          end
        end
      endcase
    end
    if (exp_res == 0 && phase != 0) exp_res = 2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid_i = 1'b0;
    repeat (gap) tick();
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic run_session(input string tag);
    model();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < bq.size(); i++) send_byte(bq[i], gq[i]);
    repeat (TMO + 4) tick();
    chk({tag, "_done"},    64'(upg_done_o), 64'(exp_res == 1));
    chk({tag, "_err"},     64'(err_o),      64'(exp_res == 2));
    chk({tag, "_cpu_rst"}, 64'(upg_rst_o),  64'(exp_res == 0));
    chk({tag, "_adr"},     64'(upg_adr_o),  64'(exp_adr));
    chk({tag, "_dat"},     64'(upg_dat_o),  64'(exp_dat));
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic set_gaps(input int g);
    gq.delete();
    foreach (bq[i]) gq.push_back(g);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wen"},  64'(upg_wen_o),  64'd0);
    chk({tag, "_adr"},  64'(upg_adr_o),  64'd0);
    chk({tag, "_dat"},  64'(upg_dat_o),  64'd0);
    chk({tag, "_done"}, 64'(upg_done_o), 64'd0);
    chk({tag, "_crst"}, 64'(upg_rst_o),  64'd0);
    chk({tag, "_err"},  64'(err_o),      64'd0);
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 2)) : int'($urandom_range(TMO - 2, TMO + 1));
  endfunction

  initial begin
    fork
      monitor();
    join_none
    rst = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();
    check_reset_outputs("idle");

    bq = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    set_gaps(2);
    run_session("two_words");

    set_gaps(0);
    run_session("back_to_back");

    bq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    set_gaps(1);
    run_session("zero_count");

    bq = '{8'hA5, 8'h01, 8'h40};
    set_gaps(0);
    run_session("too_many");

    bq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    set_gaps(0);
    run_session("silence");

    bq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    set_gaps(TMO - 1);
    run_session("gap_max");

    gq[5] = TMO;
    run_session("gap_over");

    // Reset after two of four data bytes, then a clean single-word load.
    bq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    foreach (bq[i]) send_byte(bq[i], 0);
    rst = 1'b0;
    tick();
    check_reset_outputs("mid_reset");
    rst = 1'b1;
    exp_adr = '0;
    exp_dat = '0;
    tick();
    chk("post_reset_err", 64'(err_o), 64'd0);
    bq = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    set_gaps(0);
    run_session("reload");

    for (int s = 0; s < 25; s++) begin
      int n;
      int nd;
      int sel;
      int nj;
      logic [7:0] b;
      bq.delete();
      gq.delete();
      nj = int'($urandom_range(0, 2));
      repeat (nj) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        bq.push_back(b);
        gq.push_back(int'($urandom_range(0, 3)));
      end
      bq.push_back(8'hA5);
      gq.push_back(int'($urandom_range(0, 20)));
      sel = int'($urandom_range(0, 9));
      n = (sel == 0) ? 0 : (sel == 1) ? MAXW + int'($urandom_range(1, 200)) : int'($urandom_range(1, 4));
      bq.push_back(8'(n));
      gq.push_back(rgap());
      bq.push_back(8'(n >> 8));
      gq.push_back(rgap());
      nd = (n >= 1 && n <= 4) ? 4 * n : 0;
      repeat (nd) begin
        bq.push_back(8'($urandom_range(0, 255)));
        gq.push_back(rgap());
      end
      run_session("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
